// File: rtl/fir_stream_ctrl_if.sv
// Handshake and tap-array bundle between fir_stream_ctrl and its environment.
// master is the controller's view; slave is the view of the wrappers plus tap array.
interface fir_stream_ctrl_if #(
    parameter int N    = 16,
    parameter int TAPS = 8
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [N-1:0]        cfg_data;
    logic                cfg_last;
    logic                s_valid;
    logic                s_ready;
    logic [N-1:0]        s_data;
    logic [N-1:0]        fir_sample;
    logic                fir_en;
    logic                fir_clr;
    logic [TAPS*N-1:0]   coeff_bus;
    logic [2*N-1:0]      fir_result;
    logic                m_valid;
    logic                m_ready;
    logic [2*N-1:0]      m_data;
    logic                loaded;

    modport master (
        input  cfg_valid, cfg_data, cfg_last, s_valid, s_data, fir_result, m_ready,
        output cfg_ready, s_ready, fir_sample, fir_en, fir_clr, coeff_bus, m_valid, m_data, loaded
    );

    modport slave (
        output cfg_valid, cfg_data, cfg_last, s_valid, s_data, fir_result, m_ready,
        input  cfg_ready, s_ready, fir_sample, fir_en, fir_clr, coeff_bus, m_valid, m_data, loaded
    );
endinterface

// File: rtl/fir_stream_ctrl.sv
// Streaming controller for a transposed FIR tap array with a double-buffered
// coefficient bank that swaps in only between samples.
module fir_stream_ctrl #(
    parameter int N           = 16,
    parameter int TAPS        = 8,
    parameter bit DROP_WARMUP = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    fir_stream_ctrl_if.master bus
);
    localparam int            IW       = $clog2(TAPS);
    localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

    logic [N-1:0]      shadow [TAPS];
    logic [N-1:0]      active [TAPS];
    logic [N-1:0]      smp_reg;
    logic [2*N-1:0]    res_reg;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     warm;
    logic              smp_vld;
    logic              res_vld;
    logic              loaded_q;
    logic              swap_pending;
    logic [TAPS*N-1:0] coeff_flat;

    logic cfg_ready_c;
    logic cfg_hs;
    logic last_word;
    logic swap;
    logic run_ok;
    logic fire;
    logic s_ready_c;
    logic s_hs;
    logic m_hs;
    logic keep;

    // The swap waits for the held sample to fire, so the taps never see a
    // sample multiplied partly by the old and partly by the new bank.
    always_comb begin
        cfg_ready_c = reset | !swap_pending;
        cfg_hs      = bus.cfg_valid & cfg_ready_c;
        last_word   = bus.cfg_last | (idx == LAST_IDX);
        swap        = swap_pending & !smp_vld;
        run_ok      = loaded_q & !swap_pending;
        fire        = smp_vld & (!res_vld | bus.m_ready);
        s_ready_c   = !reset & run_ok & (!smp_vld | fire);
        s_hs        = bus.s_valid & s_ready_c;
        m_hs        = res_vld & bus.m_ready;
        keep        = !DROP_WARMUP || (warm == LAST_IDX);
    end

    always_comb begin
        coeff_flat = '0;
        for (int k = 0; k < TAPS; k++) begin
            coeff_flat[k*N +: N] = active[k];
        end
    end

    assign bus.cfg_ready  = cfg_ready_c;
    assign bus.s_ready    = s_ready_c;
    assign bus.fir_sample = smp_reg;
    assign bus.fir_en     = fire & !reset;
    assign bus.fir_clr    = reset | swap;
    assign bus.coeff_bus  = coeff_flat;
    assign bus.m_valid    = res_vld;
    assign bus.m_data     = res_reg;
    assign bus.loaded     = loaded_q;

    // A short set zero-fills the remaining shadow taps so stale words never leak in.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
            idx          <= '0;
            loaded_q     <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            if (cfg_hs) begin
                for (int k = 0; k < TAPS; k++) begin
                    if (IW'(k) == idx) begin
                        shadow[k] <= bus.cfg_data;
                    end else if (last_word && (IW'(k) > idx)) begin
                        shadow[k] <= '0;
                    end
                end
                idx <= last_word ? '0 : idx + 1'b1;
            end
            if (cfg_hs && last_word) begin
                swap_pending <= 1'b1;
            end else if (swap) begin
                swap_pending <= 1'b0;
            end
            if (swap) begin
                for (int k = 0; k < TAPS; k++) begin
                    active[k] <= shadow[k];
                end
                loaded_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            smp_reg <= '0;
            smp_vld <= 1'b0;
            res_reg <= '0;
            res_vld <= 1'b0;
            warm    <= '0;
        end else begin
            if (s_hs) begin
                smp_reg <= bus.s_data;
                smp_vld <= 1'b1;
            end else if (fire) begin
                smp_vld <= 1'b0;
            end
            if (fire && keep) begin
                res_reg <= bus.fir_result;
                res_vld <= 1'b1;
            end else if (m_hs) begin
                res_vld <= 1'b0;
            end
            // Warm-up only counts discarded results, so it stops at TAPS-1.
            if (swap) begin
                warm <= '0;
            end else if (fire && !keep) begin
                warm <= warm + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl: two instances (warm-up kept / dropped) with a tap-array
// model, directed steps, then random traffic against a convolution scoreboard.
module tb_fir_stream_ctrl;
    localparam int N    = 16;
    localparam int TAPS = 4;
    localparam int ND   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [ND-1:0]      cfg_valid, cfg_last, s_valid, m_ready;
    logic [N-1:0]       cfg_data [ND];
    logic [N-1:0]       s_data [ND];
    wire  [ND-1:0]      cfg_ready, s_ready, fir_en, fir_clr, m_valid, loaded;
    wire  [TAPS*N-1:0]  coeff_bus [ND];
    wire  [2*N-1:0]     m_data [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        fir_stream_ctrl_if #(.N(N), .TAPS(TAPS)) bus ();
        logic signed [N-1:0]   hist [TAPS-1];
        logic signed [2*N-1:0] acc;

        fir_stream_ctrl #(.N(N), .TAPS(TAPS), .DROP_WARMUP(g == 1)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        assign bus.cfg_valid = cfg_valid[g];
        assign bus.cfg_data  = cfg_data[g];
        assign bus.cfg_last  = cfg_last[g];
        assign bus.s_valid   = s_valid[g];
        assign bus.s_data    = s_data[g];
        assign bus.m_ready   = m_ready[g];
        assign cfg_ready[g]  = bus.cfg_ready;
        assign s_ready[g]    = bus.s_ready;
        assign fir_en[g]     = bus.fir_en;
        assign fir_clr[g]    = bus.fir_clr;
        assign m_valid[g]    = bus.m_valid;
        assign loaded[g]     = bus.loaded;
        assign coeff_bus[g]  = bus.coeff_bus;
        assign m_data[g]     = bus.m_data;

        // Tap array stand-in: delay line honouring fir_en / fir_clr.
        always_ff @(posedge clk) begin
            if (bus.fir_clr) begin
                for (int k = 0; k < TAPS - 1; k++) hist[k] <= '0;
            end else if (bus.fir_en) begin
                hist[0] <= bus.fir_sample;
                for (int k = 1; k < TAPS - 1; k++) hist[k] <= hist[k-1];
            end
        end

        always_comb begin
            acc = $signed(bus.coeff_bus[N-1:0]) * $signed(bus.fir_sample);
            for (int k = 1; k < TAPS; k++) begin
                acc = acc + $signed(bus.coeff_bus[k*N +: N]) * hist[k-1];
            end
        end
        assign bus.fir_result = acc;
    end

    int errors = 0;
    int checks = 0;

    shortint        coef_m   [ND][TAPS];
    shortint        shadow_m [ND][TAPS];
    int             idx_m    [ND];
    shortint        xh       [ND][$];
    int             since_clr[ND];
    logic [2*N-1:0] exp_q    [ND][$];
    logic [2*N-1:0] got_q    [ND][$];
    int             fir_en_cnt [ND];
    int             fir_clr_cnt[ND];
    bit             s_hs_last  [ND];
    bit             c_hs_last  [ND];

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_m[d][k]   = 0;
                shadow_m[d][k] = 0;
            end
            idx_m[d]     = 0;
            since_clr[d] = 0;
            xh[d].delete();
            exp_q[d].delete();
        end
    endtask

    // Expected output = convolution of the samples since the last swap with the set
    // that was complete when the sample was accepted.
    task automatic model_sample(input int d, input shortint x);
        int y;
        xh[d].push_front(x);
        if (xh[d].size() > TAPS) void'(xh[d].pop_back());
        y = 0;
        for (int k = 0; k < xh[d].size(); k++) y += int'(coef_m[d][k]) * int'(xh[d][k]);
        if (d == 0 || since_clr[d] == TAPS - 1) exp_q[d].push_back(y);
        else since_clr[d]++;
    endtask

    task automatic model_cfg(input int d, input shortint w, input logic last);
        shadow_m[d][idx_m[d]] = w;
        if (last || idx_m[d] == TAPS - 1) begin
            for (int k = idx_m[d] + 1; k < TAPS; k++) shadow_m[d][k] = 0;
            for (int k = 0; k < TAPS; k++) coef_m[d][k] = shadow_m[d][k];
            idx_m[d]     = 0;
            since_clr[d] = 0;
            xh[d].delete();
        end else begin
            idx_m[d]++;
        end
    endtask

    // One clock: sample handshakes mid-cycle, update the scoreboard, return at negedge.
    task automatic tick();
        logic [2*N-1:0] e;
        #1;
        for (int d = 0; d < ND; d++) begin
            s_hs_last[d] = 1'b0;
            c_hs_last[d] = 1'b0;
            if (!reset) begin
                if (fir_en[d] === 1'b1) fir_en_cnt[d]++;
                if (fir_clr[d] === 1'b1) fir_clr_cnt[d]++;
                if (m_valid[d] && m_ready[d]) begin
                    got_q[d].push_back(m_data[d]);
                    if (exp_q[d].size() == 0) begin
                        check_output($sformatf("unexpected_result%0d", d), 64'(m_valid[d]), 64'd0);
                    end else begin
                        e = exp_q[d].pop_front();
                        check_output($sformatf("m_data%0d", d), 64'(m_data[d]), 64'(e));
                    end
                end
                if (s_valid[d] && s_ready[d]) begin
                    s_hs_last[d] = 1'b1;
                    model_sample(d, shortint'(s_data[d]));
                end
                if (cfg_valid[d] && cfg_ready[d]) begin
                    c_hs_last[d] = 1'b1;
                    model_cfg(d, shortint'(cfg_data[d]), cfg_last[d]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic send_sample(input int d, input logic [N-1:0] x);
        s_valid[d] = 1'b1;
        s_data[d]  = x;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (s_hs_last[d]) break;
        end
        s_valid[d] = 1'b0;
        check_output($sformatf("s_accept%0d", d), 64'(s_hs_last[d]), 64'd1);
    endtask

    task automatic load_set(input int d, input shortint w [TAPS], input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            cfg_valid[d] = 1'b1;
            cfg_data[d]  = w[i];
            cfg_last[d]  = use_last && (i == n - 1);
            for (int t = 0; t < 32; t++) begin
                tick();
                if (c_hs_last[d]) break;
            end
            check_output($sformatf("cfg_accept%0d", d), 64'(c_hs_last[d]), 64'd1);
        end
        cfg_valid[d] = 1'b0;
        cfg_last[d]  = 1'b0;
    endtask

    task automatic check_results(input int d, input string tag, input int n, input logic [2*N-1:0] ev [6]);
        check_output({tag, "_count"}, 64'(got_q[d].size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            check_output($sformatf("%s_%0d", tag, i), 64'(got_q[d][i]), 64'(ev[i]));
        end
    endtask

    task automatic drain(input int d);
        m_ready[d] = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check_output($sformatf("drain_left%0d", d), 64'(exp_q[d].size()), 64'd0);
        check_output($sformatf("drain_mvalid%0d", d), 64'(m_valid[d]), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        shortint        ws [TAPS];
        logic [2*N-1:0] ev [6];

        cfg_valid = '0;
        cfg_last  = '0;
        s_valid   = '0;
        m_ready   = '0;
        for (int d = 0; d < ND; d++) begin
            cfg_data[d]    = '0;
            s_data[d]      = '0;
            fir_en_cnt[d]  = 0;
            fir_clr_cnt[d] = 0;
        end
        model_reset();

        // Step 1: two reset cycles, then release.
        reset = 1'b1;
        @(negedge clk);
        check_output("rst_clr0", 64'(fir_clr), 64'b11);
        @(negedge clk);
        check_output("rst_clr1", 64'(fir_clr), 64'b11);
        check_output("rst_cfg_ready", 64'(cfg_ready), 64'b11);
        check_output("rst_s_ready", 64'(s_ready), 64'b00);
        check_output("rst_fir_en", 64'(fir_en), 64'b00);
        reset = 1'b0;
        #1;
        check_output("post_cfg_ready", 64'(cfg_ready), 64'b11);
        check_output("post_s_ready", 64'(s_ready), 64'b00);
        check_output("post_m_valid", 64'(m_valid), 64'b00);
        check_output("post_coeff", 64'(coeff_bus[0]), 64'd0);
        check_output("post_loaded", 64'(loaded), 64'b00);
        check_output("post_clr", 64'(fir_clr), 64'b00);
        @(negedge clk);

        // Step 2: full-length load without cfg_last.
        ws = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        fir_clr_cnt[0] = 0;
        load_set(0, ws, 4, 1'b0);
        check_output("pend_cfg_ready", 64'(cfg_ready[0]), 64'd0);
        check_output("pend_clr", 64'(fir_clr[0]), 64'd1);
        check_output("pend_coeff", 64'(coeff_bus[0]), 64'd0);
        check_output("pend_s_ready", 64'(s_ready[0]), 64'd0);
        tick();
        check_output("swap_coeff", 64'(coeff_bus[0]), 64'h0004_0003_0002_0001);
        check_output("swap_loaded", 64'(loaded[0]), 64'd1);
        check_output("swap_s_ready", 64'(s_ready[0]), 64'd1);
        check_output("swap_cfg_ready", 64'(cfg_ready[0]), 64'd1);
        check_output("swap_clr_pulses", 64'(fir_clr_cnt[0]), 64'd1);

        // Step 3: impulse through the filter at full throughput.
        m_ready[0] = 1'b1;
        fir_en_cnt[0] = 0;
        got_q[0].delete();
        send_sample(0, 16'd1);
        for (int i = 0; i < 4; i++) send_sample(0, 16'd0);
        for (int i = 0; i < 3; i++) tick();
        check_output("impulse_fir_en", 64'(fir_en_cnt[0]), 64'd5);
        ev = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0};
        check_results(0, "impulse", 5, ev);

        // Step 4: backpressure holds one result and one sample.
        m_ready[0] = 1'b0;
        got_q[0].delete();
        send_sample(0, 16'd7);
        send_sample(0, 16'd8);
        s_valid[0] = 1'b1;
        s_data[0]  = 16'd9;
        #1;
        check_output("bp_s_ready", 64'(s_ready[0]), 64'd0);
        check_output("bp_fir_en", 64'(fir_en[0]), 64'd0);
        check_output("bp_m_valid", 64'(m_valid[0]), 64'd1);
        tick();
        tick();
        check_output("bp_s_ready_hold", 64'(s_ready[0]), 64'd0);
        m_ready[0] = 1'b1;
        send_sample(0, 16'd9);
        drain(0);
        ev = '{32'd7, 32'd22, 32'd46, 32'd0, 32'd0, 32'd0};
        check_results(0, "bp", 3, ev);

        // Step 5: short reload while a sample is held; swap must wait for it.
        m_ready[0] = 1'b0;
        got_q[0].delete();
        send_sample(0, 16'd2);
        send_sample(0, 16'd3);
        ws = '{16'sd5, 16'sd6, 16'sd0, 16'sd0};
        fir_clr_cnt[0] = 0;
        load_set(0, ws, 2, 1'b1);
        check_output("defer_cfg_ready", 64'(cfg_ready[0]), 64'd0);
        check_output("defer_clr", 64'(fir_clr[0]), 64'd0);
        tick();
        check_output("defer_coeff", 64'(coeff_bus[0]), 64'h0004_0003_0002_0001);
        check_output("defer_s_ready", 64'(s_ready[0]), 64'd0);
        m_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_output("defer_new_coeff", 64'(coeff_bus[0]), 64'h0000_0000_0006_0005);
        check_output("defer_clr_pulses", 64'(fir_clr_cnt[0]), 64'd1);
        check_output("defer_cfg_ready_back", 64'(cfg_ready[0]), 64'd1);
        send_sample(0, 16'd10);
        send_sample(0, 16'd1);
        drain(0);
        ev = '{32'd72, 32'd66, 32'd50, 32'd65, 32'd0, 32'd0};
        check_results(0, "defer", 4, ev);

        // Step 6: warm-up suppression on the DROP_WARMUP instance.
        ws = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        load_set(1, ws, 4, 1'b0);
        tick();
        m_ready[1] = 1'b1;
        got_q[1].delete();
        for (int i = 1; i <= 6; i++) send_sample(1, N'(i));
        drain(1);
        ev = '{32'd10, 32'd14, 32'd18, 32'd0, 32'd0, 32'd0};
        check_results(1, "warm", 3, ev);
        load_set(1, ws, 4, 1'b0);
        tick();
        got_q[1].delete();
        for (int i = 1; i <= 4; i++) send_sample(1, N'(i));
        drain(1);
        ev = '{32'd10, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        check_results(1, "rewarm", 1, ev);

        // Step 7: random traffic on both instances, including reloads mid-stream.
        for (int c = 0; c < 800; c++) begin
            for (int d = 0; d < ND; d++) begin
                cfg_valid[d] = ($urandom_range(0, 7) == 0);
                cfg_data[d]  = N'($urandom);
                cfg_last[d]  = ($urandom_range(0, 2) == 0);
                s_valid[d]   = ($urandom_range(0, 3) != 0);
                s_data[d]    = N'($urandom);
                m_ready[d]   = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        cfg_valid = '0;
        cfg_last  = '0;
        s_valid   = '0;
        for (int d = 0; d < ND; d++) drain(d);

        // Step 8: reset mid-stream discards held sample and result.
        m_ready[0] = 1'b0;
        send_sample(0, 16'd3);
        send_sample(0, 16'd4);
        reset = 1'b1;
        tick();
        model_reset();
        reset = 1'b0;
        #1;
        check_output("midrst_m_valid", 64'(m_valid), 64'b00);
        check_output("midrst_loaded", 64'(loaded), 64'b00);
        check_output("midrst_coeff", 64'(coeff_bus[0]), 64'd0);
        check_output("midrst_s_ready", 64'(s_ready), 64'b00);
        check_output("midrst_cfg_ready", 64'(cfg_ready), 64'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
